s2p_frame_ctrl: RTL and testbench
=================================

// Module: s2p_frame_ctrl
// PURPOSE
//  Frame sequencer for the s_to_p / p_to_s pair. Gates serial samples into s_to_p,
//  counts a FRAME_LEN-sample frame, hands the parallel frame to the processing stage
//  over a valid/ready handshake, then runs the p_to_s unload count. Sits between the
//  sync/preamble detector and the s2p -> proc -> p2s datapath.
// PARAMETERS
//  FRAME_LEN  64  samples per frame; matches s_to_p output count
//  CNT_W      6   counter width; must satisfy 2**CNT_W >= FRAME_LEN
// PORTS
//  clk             in   1      system clock
//  reset           in   1      synchronous, active-low reset
//  i_sync          in   1      start-of-frame pulse from detector
//  i_sample_valid  in   1      serial sample present on s_to_p input this cycle
//  o_s2p_shift_en  out  1      s_to_p shift enable
//  o_sample_idx    out  CNT_W  index of the next sample to capture
//  o_frame_valid   out  1      parallel frame stable, offered downstream
//  i_frame_ready   in   1      downstream accepts the frame
//  o_p2s_load      out  1      1-cycle pulse: p_to_s loads the parallel word
//  o_p2s_shift_en  out  1      p_to_s shift enable
//  i_out_ready     in   1      serial output sink ready
//  o_busy          out  1      FSM not IDLE, or unload in progress
//  o_overrun       out  1      sticky: sample dropped in HANDOFF
// BEHAVIOUR
//  - Reset (reset==0 at posedge): FSM=IDLE, idx=0, unload cnt=0; every output 0. Takes
//    effect mid-frame or mid-unload; the partial frame is discarded.
//  - FSM states: IDLE, CAPTURE, HANDOFF.
//    IDLE: i_sync -> CAPTURE, idx<=0. i_sample_valid is ignored.
//    CAPTURE: o_s2p_shift_en = i_sample_valid (combinational, same cycle). Each valid
//      sample: idx<=idx+1. Valid sample at idx==FRAME_LEN-1 -> HANDOFF, idx<=0.
//      i_sync in CAPTURE: resync, idx<=0, stay in CAPTURE. If the same cycle also has a
//      valid sample, that sample is captured as idx 0 and idx<=1.
//    HANDOFF: o_frame_valid=1 (registered, asserted from the first HANDOFF cycle).
//      o_s2p_shift_en=0. Handshake = o_frame_valid & i_frame_ready & unload idle.
//      o_frame_valid stays high until the handshake, even while unload is busy.
//      On handshake: o_p2s_load=1 in the next cycle; unload cnt<=FRAME_LEN; FSM exits
//      (see CONFIGURATION).
//  - Overrun: i_sample_valid in HANDOFF sets o_overrun, and the sample is dropped.
//    o_overrun clears only on reset.
//  - Unload: runs in parallel with CAPTURE of the next frame.
//    o_p2s_shift_en = (cnt!=0) & i_out_ready & ~o_p2s_load. Each shift: cnt--.
//    Unload is idle when cnt==0.
//  - The load pulse and the first shift are never in the same cycle. The first shift
//    can occur 2 cycles after the handshake.
//  - Latency: last sample accepted -> o_frame_valid: 1 cycle.
//  - o_busy = (state!=IDLE) | (cnt!=0).
//  - Counters never wrap: idx is saturated by the FSM transition, and cnt stops at 0.
// CONFIGURATION
//  S2P_FRAME_CTRL_CONT_EN defined: after the handshake, FSM -> CAPTURE directly.
//    Back-to-back frames need no new i_sync. i_sync still resyncs.
//  Undefined: after the handshake, FSM -> IDLE. Every frame needs its own i_sync.
// TESTING
//  1 Reset held 3 cycles with i_sync/i_sample_valid high -> all outputs 0, o_busy=0.
//  2 i_sync, then 64 consecutive valid samples -> 64 shift_en pulses, o_sample_idx 0..63,
//    o_frame_valid rises 1 cycle after the 64th; i_frame_ready=1 -> o_p2s_load one cycle
//    later, then 64 o_p2s_shift_en pulses with i_out_ready=1.
//  3 Valid samples every other cycle -> frame_valid only after the 64th valid sample;
//    idx holds on gaps.
//  4 i_sync at idx=20 while valid -> idx returns to 1; frame completes 63 valids later.
//  5 Hold i_frame_ready=0 and drive 5 valid samples in HANDOFF -> o_overrun=1 (sticky),
//    no shift_en; then ready=1 -> handshake OK, o_overrun stays 1.
//  6 CONT_EN: two frames back-to-back with one i_sync -> second handshake deferred until
//    unload cnt==0 if i_out_ready is throttled 50%. Without CONT_EN -> FSM idles after
//    the first frame.

Source files
------------

// File: rtl/s2p_frame_ctrl.sv
// Frame sequencer: gates serial samples into s_to_p, hands each FRAME_LEN-sample frame downstream, then paces the p_to_s unload.
// Latency: o_frame_valid rises 1 cycle after the last accepted sample; o_p2s_load follows the handshake by 1 cycle; first unload shift comes 2 cycles after the handshake.
// Backpressure: o_frame_valid holds until i_frame_ready while the unload is idle; samples arriving in HANDOFF are dropped and flagged on o_overrun; unload stalls on i_out_ready.
// Optional: define S2P_FRAME_CTRL_CONT_EN to re-enter CAPTURE straight after a handshake (back-to-back frames without a new i_sync).
module s2p_frame_ctrl #(
    parameter int FRAME_LEN = 64,
    parameter int CNT_W     = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_sync,
    input  logic             i_sample_valid,
    output logic             o_s2p_shift_en,
    output logic [CNT_W-1:0] o_sample_idx,
    output logic             o_frame_valid,
    input  logic             i_frame_ready,
    output logic             o_p2s_load,
    output logic             o_p2s_shift_en,
    input  logic             i_out_ready,
    output logic             o_busy,
    output logic             o_overrun
);

    // The unload counter must hold FRAME_LEN itself, so it needs one more bit than idx.
    localparam int UCNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0]  IDX_LAST  = CNT_W'(FRAME_LEN - 1);
    localparam logic [UCNT_W-1:0] UCNT_LOAD = UCNT_W'(FRAME_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_HANDOFF
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  idx;
    logic [CNT_W-1:0]  idx_nxt;
    logic [UCNT_W-1:0] ucnt;
    logic              frame_valid;
    logic              p2s_load;
    logic              overrun;
    logic              s2p_shift;
    logic              unload_idle;
    logic              handshake;
    logic              p2s_shift;

    assign unload_idle = (ucnt == '0);
    assign handshake   = frame_valid & i_frame_ready & unload_idle;
    // Never shift in the load cycle: p_to_s is busy taking the parallel word.
    assign p2s_shift   = ~unload_idle & i_out_ready & ~p2s_load;

    // Next-state and capture-index logic for the frame FSM.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        s2p_shift = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_sync) begin
                    state_nxt = S_CAPTURE;
                    idx_nxt   = '0;
                end
            end
            S_CAPTURE: begin
                s2p_shift = i_sample_valid;
                if (i_sync) begin
                    // Resync: a sample arriving with the sync pulse becomes sample 0.
                    idx_nxt = i_sample_valid ? CNT_W'(1) : '0;
                end else if (i_sample_valid) begin
                    if (idx == IDX_LAST) begin
                        state_nxt = S_HANDOFF;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            S_HANDOFF: begin
                if (handshake) begin
`ifdef S2P_FRAME_CTRL_CONT_EN
                    state_nxt = S_CAPTURE;
`else
                    state_nxt = S_IDLE;
`endif
                    idx_nxt = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // FSM state, capture index and registered frame-valid flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            frame_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            frame_valid <= (state_nxt == S_HANDOFF);
        end
    end

    // Unload side: load pulse after the handshake, then count down one per shift.
    always_ff @(posedge clk) begin
        if (!reset) begin
            p2s_load <= 1'b0;
            ucnt     <= '0;
        end else begin
            p2s_load <= handshake;
            if (handshake) begin
                ucnt <= UCNT_LOAD;
            end else if (p2s_shift) begin
                ucnt <= ucnt - 1'b1;
            end
        end
    end

    // Sticky overrun: any sample offered while the frame is parked in HANDOFF is lost.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if ((state == S_HANDOFF) && i_sample_valid) begin
            overrun <= 1'b1;
        end
    end

    assign o_s2p_shift_en = s2p_shift;
    assign o_sample_idx   = idx;
    assign o_frame_valid  = frame_valid;
    assign o_p2s_load     = p2s_load;
    assign o_p2s_shift_en = p2s_shift;
    assign o_busy         = (state != S_IDLE) | ~unload_idle;
    assign o_overrun      = overrun;

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Scoreboard bench for s2p_frame_ctrl: stimulus pushes expected sample indices and handshakes.
// A negedge monitor pops and compares on every shift/load the DUT presents.
// Inputs change 1 time unit after the rising edge.
module tb_s2p_frame_ctrl;

    localparam int FL = 64;

    logic       clk;
    logic       reset;
    logic       sync;
    logic       sval;
    logic       frdy;
    logic       ordy;
    logic       throttle;
    logic       s2p_en;
    logic [5:0] sidx;
    logic       fv;
    logic       load;
    logic       p2s_en;
    logic       busy;
    logic       ovr;

    int n_chk    = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int exp_idx[$];
    int exp_load[$];
    int t63      = -10;
    bit prev_fv  = 1'b0;
    int n_load   = 0;
    int n_pshift = 0;
    int since    = 0;
    int e_mon;

    s2p_frame_ctrl #(.FRAME_LEN(FL), .CNT_W(6)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_sync         (sync),
        .i_sample_valid (sval),
        .o_s2p_shift_en (s2p_en),
        .o_sample_idx   (sidx),
        .o_frame_valid  (fv),
        .i_frame_ready  (frdy),
        .o_p2s_load     (load),
        .o_p2s_shift_en (p2s_en),
        .i_out_ready    (ordy),
        .o_busy         (busy),
        .o_overrun      (ovr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Output-ready driver: constant 1, or toggling every cycle when throttled.
    initial begin
        ordy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ordy = throttle ? ~ordy : 1'b1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        sync = 1'b1;
        tick();
        sync = 1'b0;
    endtask

    // Drive n consecutive valid samples; the DUT should show indices first..first+n-1.
    task automatic feed(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            sval = 1'b1;
            exp_idx.push_back(first + i);
            tick();
        end
        sval = 1'b0;
    endtask

    // Wait until nl frames have been loaded and fully shifted out.
    task automatic wait_drain(input int nl);
        int k;
        k = 0;
        while (k < 3000 && !(n_load == nl && n_pshift == FL * nl)) begin
            tick();
            k++;
        end
        chk("drain_done", (n_load == nl && n_pshift == FL * nl) ? 1 : 0, 1);
    endtask

    // Monitor: compares every output event against the scoreboard queues.
    always @(negedge clk) begin
        if (reset) begin
            if (s2p_en) begin
                if (exp_idx.size() == 0) begin
                    chk("unexpected_s2p_shift", 1, 0);
                end else begin
                    e_mon = exp_idx.pop_front();
                    chk("sample_idx", int'(sidx), e_mon);
                end
                if (sidx == 6'd63) t63 = cyc;
            end
            if (fv && !prev_fv) chk("fv_latency", cyc, t63 + 1);
            if (load) begin
                if (exp_load.size() == 0) begin
                    chk("unexpected_load", 1, 0);
                end else begin
                    void'(exp_load.pop_front());
                    chk("load_after_handshake", (prev_fv && !fv) ? 1 : 0, 1);
                end
                if (n_load > 0) chk("unload_len", since, FL);
                since = 0;
                n_load++;
            end
            if (p2s_en) begin
                chk("p2s_shift_legal", (!load && ordy) ? 1 : 0, 1);
                since++;
                n_pshift++;
                if (since > FL) chk("unload_too_long", since, FL);
            end
        end
        prev_fv = fv;
    end

    initial begin
        reset    = 1'b0;
        sync     = 1'b1;
        sval     = 1'b1;
        frdy     = 1'b1;
        throttle = 1'b0;

        // Reset held 3 cycles with sync/valid high.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_outputs", int'({s2p_en, sidx, fv, load, p2s_en, busy, ovr}), 0);
        end
        sync  = 1'b0;
        sval  = 1'b0;
        reset = 1'b1;
        tick();
        chk("idle_busy", int'(busy), 0);

        // Single back-to-back frame with ready downstream.
        start_frame();
        chk("capture_busy", int'(busy), 1);
        chk("capture_idx", int'(sidx), 0);
        exp_load.push_back(1);
        feed(0, FL);
        chk("fv_after_frame", int'(fv), 1);
        tick();
        chk("load_pulse", int'(load), 1);
        tick();
        chk("load_one_cycle", int'(load), 0);
        wait_drain(1);
`ifndef S2P_FRAME_CTRL_CONT_EN
        chk("idle_after_unload", int'(busy), 0);
`endif

        // Samples every other cycle: idx holds across gaps.
        start_frame();
        exp_load.push_back(2);
        for (int i = 0; i < FL; i++) begin
            sval = 1'b1;
            exp_idx.push_back(i);
            tick();
            sval = 1'b0;
            tick();
            if (i < FL - 1) begin
                chk("gap_idx_hold", int'(sidx), i + 1);
                chk("no_early_fv", int'(fv), 0);
            end
        end
        wait_drain(2);

        // Resync at idx 20 with a valid sample: that sample becomes sample 0.
        start_frame();
        feed(0, 20);
        sync = 1'b1;
        sval = 1'b1;
        exp_idx.push_back(20);
        tick();
        sync = 1'b0;
        sval = 1'b0;
        chk("resync_idx", int'(sidx), 1);
        exp_load.push_back(3);
        feed(1, FL - 1);
        chk("fv_after_resync", int'(fv), 1);
        wait_drain(3);

        // Overrun: downstream not ready, 5 samples offered in HANDOFF.
        chk("overrun_clear", int'(ovr), 0);
        frdy = 1'b0;
        start_frame();
        feed(0, FL);
        sval = 1'b1;
        repeat (5) tick();
        sval = 1'b0;
        chk("overrun_set", int'(ovr), 1);
        chk("fv_held", int'(fv), 1);
        chk("no_load_not_ready", int'(load), 0);
        frdy = 1'b1;
        exp_load.push_back(4);
        tick();
        chk("load_after_ready", int'(load), 1);
        wait_drain(4);
        chk("overrun_sticky", int'(ovr), 1);

        // Continuation behaviour with output throttled to 50%.
        throttle = 1'b1;
        start_frame();
        exp_load.push_back(5);
        feed(0, FL);
        tick();
        chk("load5", int'(load), 1);
`ifdef S2P_FRAME_CTRL_CONT_EN
        exp_load.push_back(6);
        feed(0, FL);
        chk("cont_fv2", int'(fv), 1);
        chk("cont_unload_running", (n_pshift < FL * 5) ? 1 : 0, 1);
        tick();
        chk("cont_deferred_fv", int'(fv), 1);
        chk("cont_deferred_load", int'(load), 0);
        wait_drain(6);
`else
        sval = 1'b1;
        repeat (FL) tick();
        sval = 1'b0;
        chk("idle_no_capture_fv", int'(fv), 0);
        chk("idle_no_capture_idx", int'(sidx), 0);
        wait_drain(5);
        chk("idle_after_frame", int'(busy), 0);
`endif
        throttle = 1'b0;

        // Reset mid-frame discards the partial frame.
        start_frame();
        feed(0, 10);
        reset = 1'b0;
        tick();
        chk("midframe_reset", int'({s2p_en, sidx, fv, load, p2s_en, busy, ovr}), 0);
        reset = 1'b1;
        tick();
        chk("post_reset_overrun", int'(ovr), 0);

        chk("idx_queue_empty", exp_idx.size(), 0);
        chk("load_queue_empty", exp_load.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
